// File: rtl/regfile_mp.sv
// Multi-port register file with an integrated busy scoreboard; register 0 reads as zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 1,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  output logic                rd_eq,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                al_en,
  input  logic [AW-1:0]       al_addr,
  output logic [NREGS-1:0]    busy_vec
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Ports are visited in ascending order so the highest-index writer wins; alloc is applied
  // after the writes so a new producer supersedes a same-cycle writeback.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int w = 0; w < NWR; w++) begin
      if (wr_en[w] && (wr_addr[w*AW +: AW] != '0)) begin
        regs_d[wr_addr[w*AW +: AW]] = wr_data[w*XLEN +: XLEN];
        busy_d[wr_addr[w*AW +: AW]] = 1'b0;
      end
    end
    if (al_en && (al_addr != '0)) begin
      busy_d[al_addr] = 1'b1;
    end
    if (rst) begin
      regs_d = '{default: '0};
      busy_d = '0;
    end
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
    busy_q <= busy_d;
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_data[i*XLEN +: XLEN] = regs_q[rd_addr[i*AW +: AW]];
      rd_busy[i]              = busy_q[rd_addr[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
      // A same-cycle writeback resolves the hazard unless this cycle also re-allocates it.
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w] && (wr_addr[w*AW +: AW] == rd_addr[i*AW +: AW]) &&
            (rd_addr[i*AW +: AW] != '0)) begin
          rd_data[i*XLEN +: XLEN] = wr_data[w*XLEN +: XLEN];
          if (!(al_en && (al_addr == rd_addr[i*AW +: AW]))) begin
            rd_busy[i] = 1'b0;
          end
        end
      end
`endif
    end
  end

  assign rd_eq    = (rd_data[0 +: XLEN] == rd_data[XLEN +: XLEN]);
  assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (two read ports, two write ports).
module tb_regfile_mp;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = 5;

  logic                clk;
  logic                rst;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                rd_eq;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                al_en;
  logic [AW-1:0]       al_addr;
  logic [NREGS-1:0]    busy_vec;

  int checks;
  int errors;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .rd_eq    (rd_eq),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .al_en    (al_en),
    .al_addr  (al_addr),
    .busy_vec (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    wr_en   = '0;
    wr_addr = '0;
    wr_data = '0;
    al_en   = 1'b0;
    al_addr = '0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic drive_wr(input int p, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    wr_en[p]               = 1'b1;
    wr_addr[p*AW +: AW]    = a;
    wr_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    set_rd(5'd0, 5'd0);
    tick();
    tick();
    rst = 1'b0;
    for (int a = 0; a < NREGS; a++) begin
      set_rd(AW'(a), AW'(NREGS - 1 - a));
      #1;
      checks++;
      if (rd_data !== '0) begin
        errors++;
        $display("[TB] FAIL reset_rd_data addr %0d: got %h expected 0", a, rd_data);
      end
      checks++;
      if (rd_busy !== 2'b00 || rd_eq !== 1'b1) begin
        errors++;
        $display("[TB] FAIL reset_busy_eq addr %0d: got busy=%b eq=%b expected busy=00 eq=1",
                 a, rd_busy, rd_eq);
      end
    end
    checks++;
    if (busy_vec !== '0) begin
      errors++;
      $display("[TB] FAIL reset_busy_vec: got %h expected 0", busy_vec);
    end
  endtask

  task automatic test_write_read();
    drive_wr(0, 5'd5, 64'hDEADBEEF_00000001);
    tick();
    clear_inputs();
    set_rd(5'd5, 5'd0);
    #1;
    checks++;
    if (rd_data[63:0] !== 64'hDEADBEEF_00000001) begin
      errors++;
      $display("[TB] FAIL write_read_p0: got %h expected deadbeef00000001", rd_data[63:0]);
    end
    checks++;
    if (rd_data[127:64] !== 64'h0 || rd_eq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL write_read_p1_eq: got %h eq=%b expected 0 eq=0", rd_data[127:64], rd_eq);
    end
  endtask

  task automatic test_zero_reg();
    drive_wr(0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    al_en   = 1'b1;
    al_addr = 5'd0;
    tick();
    clear_inputs();
    set_rd(5'd0, 5'd5);
    #1;
    checks++;
    if (rd_data[63:0] !== 64'h0 || rd_busy[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_reg_read: got %h busy=%b expected 0 busy=0", rd_data[63:0], rd_busy[0]);
    end
    checks++;
    if (busy_vec[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_reg_busy: got %b expected 0", busy_vec[0]);
    end
  endtask

  task automatic test_same_addr();
    drive_wr(0, 5'd7, 64'h11);
    drive_wr(1, 5'd7, 64'h22);
    tick();
    clear_inputs();
    set_rd(5'd7, 5'd7);
    #1;
    checks++;
    if (rd_data[63:0] !== 64'h22 || rd_eq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL same_addr_priority: got %h eq=%b expected 22 eq=1", rd_data[63:0], rd_eq);
    end
  endtask

  task automatic test_busy();
    al_en   = 1'b1;
    al_addr = 5'd3;
    tick();
    clear_inputs();
    set_rd(5'd3, 5'd5);
    #1;
    checks++;
    if (rd_busy !== 2'b01 || busy_vec !== 32'h0000_0008) begin
      errors++;
      $display("[TB] FAIL alloc_busy: got rd_busy=%b vec=%h expected 01 00000008", rd_busy, busy_vec);
    end
    drive_wr(0, 5'd3, 64'h55);
    #1;
    checks++;
`ifdef REGFILE_BYPASS_EN
    if (rd_busy[0] !== 1'b0 || rd_data[63:0] !== 64'h55) begin
      errors++;
      $display("[TB] FAIL wb_same_cycle: got busy=%b data=%h expected 0 55", rd_busy[0], rd_data[63:0]);
    end
`else
    if (rd_busy[0] !== 1'b1 || rd_data[63:0] !== 64'h0) begin
      errors++;
      $display("[TB] FAIL wb_same_cycle: got busy=%b data=%h expected 1 0", rd_busy[0], rd_data[63:0]);
    end
`endif
    tick();
    clear_inputs();
    #1;
    checks++;
    if (rd_busy[0] !== 1'b0 || busy_vec !== '0 || rd_data[63:0] !== 64'h55) begin
      errors++;
      $display("[TB] FAIL wb_clears_busy: got busy=%b vec=%h data=%h expected 0 0 55",
               rd_busy[0], busy_vec, rd_data[63:0]);
    end
    al_en   = 1'b1;
    al_addr = 5'd3;
    drive_wr(0, 5'd3, 64'h66);
    tick();
    clear_inputs();
    #1;
    checks++;
    if (busy_vec !== 32'h0000_0008 || rd_busy[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL alloc_beats_wb: got vec=%h busy=%b expected 00000008 1", busy_vec, rd_busy[0]);
    end
    checks++;
    if (rd_data[63:0] !== 64'h66) begin
      errors++;
      $display("[TB] FAIL alloc_wb_data: got %h expected 66", rd_data[63:0]);
    end
  endtask

  task automatic test_bypass();
    set_rd(5'd9, 5'd9);
    drive_wr(1, 5'd9, 64'h1234);
    #1;
    checks++;
`ifdef REGFILE_BYPASS_EN
    if (rd_data[63:0] !== 64'h1234 || rd_data[127:64] !== 64'h1234) begin
      errors++;
      $display("[TB] FAIL bypass_same_cycle: got %h expected 1234 on both ports", rd_data);
    end
`else
    if (rd_data[63:0] !== 64'h0 || rd_data[127:64] !== 64'h0) begin
      errors++;
      $display("[TB] FAIL bypass_same_cycle: got %h expected 0 on both ports", rd_data);
    end
`endif
    tick();
    clear_inputs();
    #1;
    checks++;
    if (rd_data[63:0] !== 64'h1234 || rd_eq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL write_next_cycle: got %h eq=%b expected 1234 eq=1", rd_data[63:0], rd_eq);
    end
  endtask

  task automatic test_back_to_back();
    set_rd(5'd10, 5'd9);
    drive_wr(0, 5'd10, 64'hA);
    tick();
    clear_inputs();
    drive_wr(0, 5'd10, 64'hB);
    #1;
    checks++;
`ifdef REGFILE_BYPASS_EN
    if (rd_data[63:0] !== 64'hB) begin
      errors++;
      $display("[TB] FAIL b2b_first: got %h expected b", rd_data[63:0]);
    end
`else
    if (rd_data[63:0] !== 64'hA) begin
      errors++;
      $display("[TB] FAIL b2b_first: got %h expected a", rd_data[63:0]);
    end
`endif
    tick();
    clear_inputs();
    #1;
    checks++;
    if (rd_data[63:0] !== 64'hB) begin
      errors++;
      $display("[TB] FAIL b2b_second: got %h expected b", rd_data[63:0]);
    end
  endtask

  task automatic test_mid_reset();
    al_en   = 1'b1;
    al_addr = 5'd12;
    tick();
    clear_inputs();
    rst     = 1'b1;
    drive_wr(0, 5'd13, 64'h99);
    al_en   = 1'b1;
    al_addr = 5'd14;
    tick();
    rst = 1'b0;
    clear_inputs();
    set_rd(5'd5, 5'd13);
    #1;
    checks++;
    if (rd_data !== '0 || rd_eq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_reset_data: got %h eq=%b expected 0 eq=1", rd_data, rd_eq);
    end
    checks++;
    if (busy_vec !== '0 || rd_busy !== 2'b00) begin
      errors++;
      $display("[TB] FAIL mid_reset_busy: got vec=%h rd_busy=%b expected 0 00", busy_vec, rd_busy);
    end
    set_rd(5'd3, 5'd9);
    #1;
    checks++;
    if (rd_data !== '0) begin
      errors++;
      $display("[TB] FAIL mid_reset_cleared: got %h expected 0", rd_data);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    clear_inputs();
    set_rd(5'd0, 5'd0);
    test_reset();
    test_write_read();
    test_zero_reg();
    test_same_addr();
    test_busy();
    test_bypass();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file; successor to the single-write, two-read regfile in the decode/RRU stage.
- Adds configurable width, depth and port counts, deterministic same-address write arbitration, and an integrated busy scoreboard for the issue stage.
- Optional same-cycle write-to-read bypass.
- Sits between decode/issue (read, alloc) and writeback (write ports).

Parameters:
- XLEN, 64, data width of each register.
- NREGS, 32, number of architectural registers; power of two, >= 2.
- NRD, 2, number of read ports; >= 2.
- NWR, 1, number of write ports; >= 1.
- AW, $clog2(NREGS), register address width (derived, not overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rd_addr  in  NRD*AW  read addresses; port i at [i*AW +: AW].
- rd_data  out  NRD*XLEN  read data per port.
- rd_busy  out  NRD  per read port: addressed register has a pending producer.
- rd_eq  out  1  rd_data port0 == rd_data port1 (branch compare).
- wr_en  in  NWR  write enable per write port.
- wr_addr  in  NWR*AW  write addresses.
- wr_data  in  NWR*XLEN  write data.
- al_en  in  1  allocate: mark al_addr busy (instruction issued with destination).
- al_addr  in  AW  destination being allocated.
- busy_vec  out  NREGS  full scoreboard, bit r = register r busy.

Behaviour:
- Storage: NREGS x XLEN array plus NREGS busy bits. Register 0 is hardwired zero: reads return 0, busy bit always 0, writes and allocs to addr 0 ignored.
- Reset (rst high at posedge): all registers cleared to 0, all busy bits cleared. Reset overrides any same-cycle write or alloc.
- Since reads are combinational, rd_data and rd_busy are 0 while the array is cleared; rd_eq = 1.
- Reset asserted mid-operation discards pending allocations; no writeback is expected afterwards.
- Write: at posedge, for each port w with wr_en[w] and wr_addr[w] != 0, reg[wr_addr[w]] <= wr_data[w].
  - Same address on several enabled ports: highest-index port wins.
  - Write clears the busy bit of that address.
- Alloc: at posedge, if al_en and al_addr != 0, busy[al_addr] <= 1.
  - Alloc and write to the same address in one cycle: alloc wins, bit ends 1 (new producer supersedes).
  - Register data is still updated by the write.
- Read: combinational. rd_data[i] = reg[rd_addr[i]] as held at the start of the cycle, so 0-cycle read latency and 1-cycle write-to-read latency.
- rd_busy[i] = busy[rd_addr[i]] at start of cycle.
- rd_eq derived from final rd_data (after bypass when enabled).
- No handshakes; all enables single-cycle pulses. Back-to-back writes to the same address each take effect in order.
- Out-of-range addresses cannot occur (NREGS power of two).

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined:
  - If any enabled write port targets rd_addr[i] != 0 in the current cycle, rd_data[i] returns that wr_data (highest-index port wins) instead of array contents.
  - rd_busy[i] is forced 0 in that case unless al_en targets the same address this cycle.
  - Zero-cycle write-to-read.
- Undefined: reads return pre-write array contents; same-cycle write invisible until next cycle.

Test Plan:
1. Reset, then read all addresses on every port -> rd_data all 0, rd_busy 0, busy_vec 0, rd_eq 1.
2. Write port0 addr 5 = 0xDEADBEEF_00000001; next cycle read port0=5, port1=0 -> rd_data0 = 0xDEADBEEF_00000001, rd_data1 = 0, rd_eq 0.
3. Write addr 0 = 0xFFFF_FFFF_FFFF_FFFF with al_en addr 0 -> read addr 0 gives 0, busy_vec[0] stays 0.
4. NWR=2: both ports write addr 7 (port0 0x11, port1 0x22) -> next cycle reg7 = 0x22.
5. Alloc addr 3 -> rd_busy 1 on a port reading 3. Then write 3 = 0x55 alone -> busy clears next cycle. Then alloc 3 and write 3 = 0x66 in the same cycle -> busy_vec[3] = 1, reg3 = 0x66.
6. Write addr 9 = 0x1234 while reading 9 in the same cycle:
   - With REGFILE_BYPASS_EN -> rd_data = 0x1234 that cycle.
   - Without -> old value (0) that cycle, 0x1234 next cycle.
   - Assert rst mid-sequence -> everything 0 next cycle.
